// File: rtl/frog_river_ctrl.sv
// River-row log-riding controller: once per frame checks whether the frog's centre
// lies on a log in its lane, emits carry pulses while riding and a drown pulse on a miss.
module frog_river_ctrl #(
  parameter logic [9:0] BLOCKSIZE       = 10'd32,
  parameter logic [9:0] X_OFFSET_RIGHT  = 10'd544,
  parameter logic [3:0] RIVER_ROW_FIRST = 4'd1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_tick,
  input  logic [9:0]     frog_x,
  input  logic [3:0]     frog_row,
  input  logic           frog_respawn,
  input  logic [179:0]   log_x,
  input  logic [59:0]    log_len,
  output logic           on_log,
  output logic           push_right,
  output logic           drown,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE, S_DEAD} state_t;

  state_t       r_state, w_next;
  logic [2:0]   r_lane;
  logic [1:0]   r_idx;
  logic         r_hit;
  logic [10:0]  r_centre;
  logic [9:0]   r_prev_x;
  logic         r_on_log, r_push, r_drown;

  logic [7:0][3:0][9:0] w_lx;
  logic [7:0][9:0]      w_ll;
  logic         w_in_river, w_edge, w_hit_k, w_start;
  logic [3:0]   w_row_off;
  logic [2:0]   w_lane;
  logic [10:0]  w_centre, w_sx, w_end;
  logic [9:0]   w_cur_x, w_new_x;
  logic         w_latch, w_drown_d, w_on_log_d, w_push_d;

  // Unused lanes/slots are zero so out-of-range lane indices read harmless values.
  always_comb begin
    w_lx = '0;
    w_ll = '0;
    for (int l = 0; l < 6; l++) begin
      w_ll[l] = log_len[10*l +: 10];
      for (int k = 0; k < 3; k++) w_lx[l][k] = log_x[30*l + 10*k +: 10];
    end
  end

  assign w_in_river = ({1'b0, frog_row} >= {1'b0, RIVER_ROW_FIRST}) &&
                      ({1'b0, frog_row} <= {1'b0, RIVER_ROW_FIRST} + 5'd5);
  assign w_row_off  = frog_row - RIVER_ROW_FIRST;
  assign w_lane     = w_row_off[2:0];
  assign w_centre   = {1'b0, frog_x} + {1'b0, (BLOCKSIZE >> 1)};
  assign w_edge     = {1'b0, frog_x} >= ({1'b0, X_OFFSET_RIGHT} - {1'b0, BLOCKSIZE});

  assign w_sx    = {1'b0, w_lx[r_lane][r_idx]};
  assign w_end   = w_sx + {1'b0, w_ll[r_lane]};
  assign w_hit_k = (r_centre >= w_sx) && (r_centre < w_end);

  assign w_cur_x = w_lx[r_lane][0];
  assign w_new_x = w_lx[w_lane][0];
  assign w_start = (r_state == S_IDLE) && !frog_respawn && frame_tick && w_in_river;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = (r_on_log && w_edge) ? S_DEAD : S_SCAN;
      end
      S_SCAN: begin
        if (frog_respawn)       w_next = S_IDLE;
        else if (r_idx == 2'd2) w_next = S_DECIDE;
      end
      S_DECIDE: begin
        if (frog_respawn) w_next = S_IDLE;
        else              w_next = r_hit ? S_IDLE : S_DEAD;
      end
      S_DEAD: begin
        if (frog_respawn) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_latch    = w_start && !(r_on_log && w_edge);
    w_drown_d  = !frog_respawn &&
                 ((w_start && r_on_log && w_edge) || (r_state == S_DECIDE && !r_hit));
    w_on_log_d = r_on_log;
    if (frog_respawn || r_state == S_DEAD || w_drown_d)                  w_on_log_d = 1'b0;
    else if (r_state == S_IDLE && frame_tick && !w_in_river)             w_on_log_d = 1'b0;
    else if (r_state == S_DECIDE)                                        w_on_log_d = r_hit;
    // A lane reload resynchronises prev_x, so no carry is taken that cycle.
    w_push_d   = r_on_log && (r_state != S_DEAD) && (w_cur_x != r_prev_x) &&
                 !w_latch && !frog_respawn && !w_drown_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_on_log <= 1'b0;
      r_push   <= 1'b0;
      r_drown  <= 1'b0;
      r_lane   <= '0;
      r_idx    <= '0;
      r_hit    <= 1'b0;
      r_centre <= '0;
      r_prev_x <= '0;
    end else begin
      r_on_log <= w_on_log_d;
      r_push   <= w_push_d;
      r_drown  <= w_drown_d;
      if (w_latch) begin
        r_lane   <= w_lane;
        r_centre <= w_centre;
        r_idx    <= '0;
        r_hit    <= 1'b0;
        r_prev_x <= w_new_x;
      end else begin
        r_prev_x <= w_cur_x;
        if (r_state == S_SCAN) begin
          r_hit <= r_hit | w_hit_k;
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  assign on_log     = r_on_log;
  assign push_right = r_push;
  assign drown      = r_drown;
  assign busy       = (r_state == S_SCAN) || (r_state == S_DECIDE);

endmodule

// File: tb/tb_frog_river_ctrl.sv
// Directed bench for frog_river_ctrl: table of per-frame decisions plus
// hand sequences for dead state, carry pulses, edge drown, off-river and reset.
module tb_frog_river_ctrl;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         frame_tick = 1'b0;
  logic [9:0]   frog_x = '0;
  logic [3:0]   frog_row = '0;
  logic         frog_respawn = 1'b0;
  logic [179:0] log_x = '0;
  logic [59:0]  log_len = '0;
  logic         on_log, push_right, drown, busy;

  int n_tests = 0;
  int n_fail  = 0;

  frog_river_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .frog_x(frog_x),
    .frog_row(frog_row), .frog_respawn(frog_respawn), .log_x(log_x),
    .log_len(log_len), .on_log(on_log), .push_right(push_right),
    .drown(drown), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] fx;
    logic [3:0] row;
    logic       exp_on;
    logic       exp_dr;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_log(input int lane, input int k, input logic [9:0] v);
    log_x[30*lane + 10*k +: 10] = v;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic respawn();
    frog_respawn = 1'b1;
    step();
    frog_respawn = 1'b0;
  endtask

  // Full frame decision: busy for 4 cycles, result at the 5th, drown one cycle wide.
  task automatic decide(input string name, input logic [9:0] fx, input logic [3:0] row,
                        input logic exp_on, input logic exp_dr);
    logic bz, dr_early;
    frog_x = fx; frog_row = row;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    bz = busy; dr_early = drown;
    repeat (3) begin
      step();
      bz &= busy; dr_early |= drown;
    end
    check({name, " busy"}, int'(bz), 1);
    check({name, " early_drown"}, int'(dr_early), 0);
    step();
    check({name, " on_log"}, int'(on_log), int'(exp_on));
    check({name, " drown"}, int'(drown), int'(exp_dr));
    check({name, " idle"}, int'(busy), 0);
    step();
    check({name, " drown_width"}, int'(drown), 0);
  endtask

  // Counts push pulses over n cycles; flags overlap with drown and multi-cycle pulses.
  task automatic count_push(input int n, output int pulses, output int bad);
    logic prev;
    pulses = 0; bad = 0; prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (push_right && !prev) pulses++;
      if (push_right && prev) bad++;
      if (push_right && drown) bad++;
      prev = push_right;
    end
  endtask

  initial begin
    int p, b;
    logic bz;

    vt[0] = '{10'd100, 4'd1, 1'b1, 1'b0};
    vt[1] = '{10'd170, 4'd1, 1'b0, 1'b1};
    vt[2] = '{10'd80,  4'd1, 1'b1, 1'b0};
    vt[3] = '{10'd144, 4'd1, 1'b0, 1'b1};
    vt[4] = '{10'd230, 4'd1, 1'b1, 1'b0};
    vt[5] = '{10'd443, 4'd1, 1'b1, 1'b0};
    vt[6] = '{10'd444, 4'd1, 1'b0, 1'b1};
    vt[7] = '{10'd100, 4'd2, 1'b0, 1'b1};
    vt[8] = '{10'd190, 4'd2, 1'b1, 1'b0};
    vt[9] = '{10'd309, 4'd6, 1'b1, 1'b0};

    set_log(0, 0, 10'd96); set_log(0, 1, 10'd246); set_log(0, 2, 10'd396);
    log_len[0 +: 10] = 10'd64;
    set_log(1, 0, 10'd0);  set_log(1, 1, 10'd200); set_log(1, 2, 10'd400);
    log_len[10 +: 10] = 10'd96;
    set_log(5, 0, 10'd300); set_log(5, 1, 10'd310); set_log(5, 2, 10'd320);
    log_len[50 +: 10] = 10'd10;

    #12;
    check("reset on_log", int'(on_log), 0);
    check("reset drown", int'(drown), 0);
    check("reset push", int'(push_right), 0);
    check("reset busy", int'(busy), 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      respawn();
      decide($sformatf("vec%0d", i), vt[i].fx, vt[i].row, vt[i].exp_on, vt[i].exp_dr);
    end

    // DEAD ignores frame_tick until respawn.
    respawn();
    decide("dead_entry", 10'd170, 4'd1, 1'b0, 1'b1);
    frog_x = 10'd100;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    bz = busy;
    repeat (5) begin step(); bz |= busy; end
    check("dead busy", int'(bz), 0);
    check("dead on_log", int'(on_log), 0);
    respawn();
    decide("after_respawn", 10'd100, 4'd1, 1'b1, 1'b0);

    // Carry pulses: two steps, then wrap.
    set_log(0, 0, 10'd97);
    count_push(3, p, b);
    set_log(0, 0, 10'd98);
    begin int p2, b2; count_push(3, p2, b2); p += p2; b += b2; end
    check("carry pulses", p, 2);
    check("carry width", b, 0);
    set_log(0, 0, 10'd544);
    count_push(3, p, b);
    set_log(0, 0, 10'd32);
    count_push(3, p, b);
    check("wrap pulses", p, 1);
    check("wrap width", b, 0);
    set_log(0, 0, 10'd96);
    step(); step();

    // Carried to the right edge: immediate drown, no scan.
    respawn();
    decide("edge_setup", 10'd100, 4'd1, 1'b1, 1'b0);
    frog_x = 10'd512;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("edge drown", int'(drown), 1);
    check("edge busy", int'(busy), 0);
    check("edge on_log", int'(on_log), 0);
    step();
    check("edge drown_width", int'(drown), 0);

    // Off-river row clears on_log without drowning.
    respawn();
    decide("bank_setup", 10'd100, 4'd1, 1'b1, 1'b0);
    frog_row = 4'd0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("bank on_log", int'(on_log), 0);
    check("bank drown", int'(drown), 0);
    check("bank busy", int'(busy), 0);

    // Respawn aborts a scan.
    decide("abort_setup", 10'd100, 4'd1, 1'b1, 1'b0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    respawn();
    check("abort busy", int'(busy), 0);
    check("abort on_log", int'(on_log), 0);

    // Asynchronous reset in the second SCAN cycle.
    decide("rst_setup", 10'd100, 4'd1, 1'b1, 1'b0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check("async on_log", int'(on_log), 0);
    check("async busy", int'(busy), 0);
    check("async drown", int'(drown), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    decide("post_reset", 10'd100, 4'd1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
